redux_sched: RTL

REDUX_SCHED -- requirements
Module: redux_sched

---
 rtl/redux_pkg.sv | 26 ++
 rtl/redux_addr_gen.sv | 44 ++++
 rtl/redux_sched.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/redux_pkg.sv
`default_nettype none
// ============================================================================
// Module   : redux_pkg
// Purpose  : Shared defaults, address widths and FSM state encoding for the
//            2x2 reduction scheduler (redux_sched / redux_addr_gen).
// Revision : 1.0 - initial release
// ============================================================================
package redux_pkg;

  localparam int HEIGHT_DEF = 120;  // source rows (even)
  localparam int WIDTH_DEF  = 160;  // source columns (multiple of 2*LANES)
  localparam int LANES_DEF  = 5;    // parallel reduction lanes

  localparam int RD_AW = 15;        // source address width
  localparam int WR_AW = 13;        // result address width

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_COMPUTE = 3'd2,
    ST_WRITE   = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

endpackage
`default_nettype wire

// File: rtl/redux_addr_gen.sv
`default_nettype none
// ============================================================================
// Module   : redux_addr_gen
// Purpose  : Combinational address generation for the reduction scheduler.
//            rd_addr = (2*row + quad[1]) * WIDTH + 2*(grp*LANES + rd_lane) + quad[0]
//            wr_addr = row * (WIDTH/2) + grp*LANES + wr_lane
// Ports    : row, grp          - output row / lane-group counters
//            rd_lane, rd_quad  - lane and quadrant (0=TL,1=TR,2=BL,3=BR) of the read
//            wr_lane           - lane being written
//            rd_addr, wr_addr  - source and result addresses
// Revision : 1.0 - initial release
// ============================================================================
module redux_addr_gen
  import redux_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int LANES  = LANES_DEF,
  parameter int ROW_W  = 6,
  parameter int GRP_W  = 4,
  parameter int LANE_W = 3
) (
  input  logic [ROW_W-1:0]  row,
  input  logic [GRP_W-1:0]  grp,
  input  logic [LANE_W-1:0] rd_lane,
  input  logic [1:0]        rd_quad,
  input  logic [LANE_W-1:0] wr_lane,
  output logic [RD_AW-1:0]  rd_addr,
  output logic [WR_AW-1:0]  wr_addr
);

  logic [31:0] src_row;
  logic [31:0] src_col;
  logic [31:0] out_col;

  always_comb begin
    src_row = 32'(row) * 32'd2 + 32'(rd_quad[1]);
    src_col = (32'(grp) * 32'(LANES) + 32'(rd_lane)) * 32'd2 + 32'(rd_quad[0]);
    out_col = 32'(grp) * 32'(LANES) + 32'(wr_lane);
    rd_addr = RD_AW'(src_row * 32'(WIDTH) + src_col);
    wr_addr = WR_AW'(32'(row) * 32'(WIDTH / 2) + out_col);
  end

endmodule
`default_nettype wire

// File: rtl/redux_sched.sv
`default_nettype none
// ============================================================================
// Module   : redux_sched
// Purpose  : Schedules a 2x2 image reduction over an external LANES-wide
//            datapath: fetches 4 pixels per lane, latches the datapath
//            result, then writes the LANES results to the sink.
// Ports    : clk, rst (sync, active-high), start / busy / done
//            rd_en, rd_addr, rd_data      - source read (1-cycle latency)
//            dp_pix_in, dp_pix_out        - external datapath operands/results
//            wr_en, wr_addr, wr_data, wr_ready - result write handshake
//            stall_cnt                    - only with REDUX_SCHED_STATS_EN
// Options  : `define REDUX_SCHED_STATS_EN adds the stall_cnt output.
// Revision : 1.0 - initial release
// ============================================================================
module redux_sched
  import redux_pkg::*;
#(
  parameter int HEIGHT = HEIGHT_DEF,
  parameter int WIDTH  = WIDTH_DEF,
  parameter int LANES  = LANES_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  rd_en,
  output logic [RD_AW-1:0]      rd_addr,
  input  logic [7:0]            rd_data,
  output logic [4*LANES*8-1:0]  dp_pix_in,
  input  logic [LANES*8-1:0]    dp_pix_out,
  output logic                  wr_en,
  output logic [WR_AW-1:0]      wr_addr,
  output logic [7:0]            wr_data,
  input  logic                  wr_ready
`ifdef REDUX_SCHED_STATS_EN
  ,
  output logic [15:0]           stall_cnt
`endif
);

  localparam int ROWS   = HEIGHT / 2;
  localparam int GROUPS = WIDTH / (2 * LANES);
  localparam int ROW_W  = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int GRP_W  = (GROUPS > 1) ? $clog2(GROUPS) : 1;
  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;

  state_t                 state_q, state_d;
  logic [ROW_W-1:0]       row_q, row_d;
  logic [GRP_W-1:0]       grp_q, grp_d;
  logic [LANE_W-1:0]      rd_lane_q, rd_lane_d;
  logic [1:0]             rd_quad_q, rd_quad_d;
  logic                   rd_issued_q, rd_issued_d;  // all reads of the group issued
  logic                   cap_vld_q, cap_vld_d;      // a read is returning this cycle
  logic [LANE_W-1:0]      cap_lane_q, cap_lane_d;
  logic [1:0]             cap_quad_q, cap_quad_d;
  logic [LANE_W-1:0]      wr_lane_q, wr_lane_d;
  logic [4*LANES*8-1:0]   pix_q, pix_d;
  logic [LANES*8-1:0]     res_q, res_d;
  logic [31:0]            cap_idx;
`ifdef REDUX_SCHED_STATS_EN
  logic [15:0]            stall_q, stall_d;
  assign stall_cnt = stall_q;
`endif

  redux_addr_gen #(
    .WIDTH  (WIDTH),
    .LANES  (LANES),
    .ROW_W  (ROW_W),
    .GRP_W  (GRP_W),
    .LANE_W (LANE_W)
  ) u_addr_gen (
    .row     (row_q),
    .grp     (grp_q),
    .rd_lane (rd_lane_q),
    .rd_quad (rd_quad_q),
    .wr_lane (wr_lane_q),
    .rd_addr (rd_addr),
    .wr_addr (wr_addr)
  );

  assign dp_pix_in = pix_q;
  assign wr_data   = res_q[wr_lane_q*8 +: 8];

  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    grp_d       = grp_q;
    rd_lane_d   = rd_lane_q;
    rd_quad_d   = rd_quad_q;
    rd_issued_d = rd_issued_q;
    wr_lane_d   = wr_lane_q;
    pix_d       = pix_q;
    res_d       = res_q;
`ifdef REDUX_SCHED_STATS_EN
    stall_d     = stall_q;
`endif
    rd_en       = 1'b0;
    wr_en       = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;

    // Returning read data is captured regardless of state so that only the
    // capture pipeline (cleared by reset) decides what is kept.
    cap_idx = 32'(cap_quad_q) * 32'(LANES) + 32'(cap_lane_q);
    if (cap_vld_q) begin
      pix_d[cap_idx*8 +: 8] = rd_data;
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d     = ST_FETCH;
          row_d       = '0;
          grp_d       = '0;
          rd_lane_d   = '0;
          rd_quad_d   = '0;
          rd_issued_d = 1'b0;
          wr_lane_d   = '0;
`ifdef REDUX_SCHED_STATS_EN
          stall_d     = '0;
`endif
        end
      end

      ST_FETCH: begin
        busy = 1'b1;
        if (!rd_issued_q) begin
          rd_en     = 1'b1;
          rd_quad_d = rd_quad_q + 2'd1;
          if (rd_quad_q == 2'd3) begin
            if (rd_lane_q == LANE_W'(LANES - 1)) begin
              rd_lane_d   = '0;
              rd_issued_d = 1'b1;
            end else begin
              rd_lane_d = rd_lane_q + LANE_W'(1);
            end
          end
        end
        // Leave once the final (last lane, BR) read is being captured.
        if (cap_vld_q && cap_quad_q == 2'd3 && cap_lane_q == LANE_W'(LANES - 1)) begin
          state_d = ST_COMPUTE;
        end
      end

      ST_COMPUTE: begin
        busy        = 1'b1;
        res_d       = dp_pix_out;
        rd_issued_d = 1'b0;
        wr_lane_d   = '0;
        state_d     = ST_WRITE;
      end

      ST_WRITE: begin
        busy  = 1'b1;
        wr_en = 1'b1;
        if (wr_ready) begin
          if (wr_lane_q == LANE_W'(LANES - 1)) begin
            wr_lane_d = '0;
            if (grp_q == GRP_W'(GROUPS - 1)) begin
              grp_d = '0;
              if (row_q == ROW_W'(ROWS - 1)) begin
                state_d = ST_DONE;
              end else begin
                row_d   = row_q + ROW_W'(1);
                state_d = ST_FETCH;
              end
            end else begin
              grp_d   = grp_q + GRP_W'(1);
              state_d = ST_FETCH;
            end
          end else begin
            wr_lane_d = wr_lane_q + LANE_W'(1);
          end
        end
`ifdef REDUX_SCHED_STATS_EN
        else if (stall_q != 16'hFFFF) begin
          stall_d = stall_q + 16'd1;
        end
`endif
      end

      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase

    cap_vld_d  = rd_en;
    cap_lane_d = rd_lane_q;
    cap_quad_d = rd_quad_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      row_q       <= '0;
      grp_q       <= '0;
      rd_lane_q   <= '0;
      rd_quad_q   <= '0;
      rd_issued_q <= 1'b0;
      cap_vld_q   <= 1'b0;
      cap_lane_q  <= '0;
      cap_quad_q  <= '0;
      wr_lane_q   <= '0;
      pix_q       <= '0;
      res_q       <= '0;
`ifdef REDUX_SCHED_STATS_EN
      stall_q     <= '0;
`endif
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      grp_q       <= grp_d;
      rd_lane_q   <= rd_lane_d;
      rd_quad_q   <= rd_quad_d;
      rd_issued_q <= rd_issued_d;
      cap_vld_q   <= cap_vld_d;
      cap_lane_q  <= cap_lane_d;
      cap_quad_q  <= cap_quad_d;
      wr_lane_q   <= wr_lane_d;
      pix_q       <= pix_d;
      res_q       <= res_d;
`ifdef REDUX_SCHED_STATS_EN
      stall_q     <= stall_d;
`endif
    end
  end

endmodule
`default_nettype wire
